// File: rtl/rgb_seq_multi.sv
// ---------------------------------------------------------------------------
// rgb_seq_multi
//
// Multi-channel RGB light sequencer. Each channel walks a palette index
// between SEQ_MIN and SEQ_MAX while its button is held. The channel dwells
// on each colour for threshold+1 enabled clocks before it moves on. Each
// channel has its own sequencing mode (forward, bounce, reverse or hold) and
// its own white override. The dwell threshold is shared by all channels.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   button      per-channel sequence enable
//   lights_sel  per-channel select: 1 = sequencer colour, 0 = forced white
//   mode        per-channel mode, channel c at [2c+1:2c]
//                 00 forward, 01 bounce, 10 reverse, 11 hold
//   threshold   shared dwell threshold (unsigned)
//   lights_out  per-channel RGB word {R,G,B}, channel c in slice c
//   colour_idx  per-channel current palette index (3 bits per channel)
//   step        one-cycle pulse per channel after each index advance
// ---------------------------------------------------------------------------
module rgb_seq_multi #(
    parameter int CHANNELS = 2,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 6,
    parameter int SEQ_MIN  = 1,
    parameter int SEQ_MAX  = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CHANNELS-1:0]             button,
    input  logic [CHANNELS-1:0]             lights_sel,
    input  logic [2*CHANNELS-1:0]           mode,
    input  logic [CNT_W-1:0]                threshold,
    output logic [CHANNELS*3*COLOR_W-1:0]   lights_out,
    output logic [3*CHANNELS-1:0]           colour_idx,
    output logic [CHANNELS-1:0]             step
);

    localparam int         RGB_W   = 3 * COLOR_W;
    localparam logic [2:0] IDX_MIN = 3'(SEQ_MIN);
    localparam logic [2:0] IDX_MAX = 3'(SEQ_MAX);

    typedef enum logic [1:0] {
        MODE_FWD    = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_REV    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Each index bit drives one whole colour component fully on or fully off.
    function automatic logic [RGB_W-1:0] palette(input logic [2:0] i);
        return {{COLOR_W{i[2]}}, {COLOR_W{i[1]}}, {COLOR_W{i[0]}}};
    endfunction

    // Next {dir, idx} for one advance. In bounce mode the direction flips
    // on the same advance that leaves an end, so an end index is never
    // shown twice in a row.
    function automatic logic [3:0] next_pos(input logic [2:0] idx,
                                            input mode_t     md,
                                            input logic      dir);
        logic [2:0] n_idx;
        logic       n_dir;
        n_idx = idx;
        n_dir = dir;
        case (md)
            MODE_FWD: n_idx = (idx >= IDX_MAX) ? IDX_MIN : idx + 3'd1;
            MODE_REV: n_idx = (idx <= IDX_MIN) ? IDX_MAX : idx - 3'd1;
            MODE_BOUNCE: begin
                if (dir) begin
                    if (idx >= IDX_MAX) begin
                        n_dir = 1'b0;
                        n_idx = idx - 3'd1;
                    end else begin
                        n_idx = idx + 3'd1;
                    end
                end else begin
                    if (idx <= IDX_MIN) begin
                        n_dir = 1'b1;
                        n_idx = idx + 3'd1;
                    end else begin
                        n_idx = idx - 3'd1;
                    end
                end
            end
            default: ;
        endcase
        return {n_dir, n_idx};
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [2:0]       idx;
        logic [CNT_W-1:0] cnt;
        logic             dir;
        logic [RGB_W-1:0] colour_q;
        logic             step_q;
        mode_t            ch_mode;
        logic             enabled;
        logic [3:0]       nxt;

        assign ch_mode = mode_t'(mode[2*c +: 2]);
        assign enabled = button[c] && (ch_mode != MODE_HOLD);
        assign nxt     = next_pos(idx, ch_mode, dir);

        // Hold and a released button both freeze the dwell counter without
        // clearing it, so resuming finishes only the remaining dwell. The
        // colour register trails idx by one clock on every edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idx      <= IDX_MIN;
                cnt      <= '0;
                dir      <= 1'b1;
                colour_q <= palette(IDX_MIN);
                step_q   <= 1'b0;
            end else begin
                colour_q <= palette(idx);
                step_q   <= 1'b0;
                if (enabled) begin
                    if (cnt >= threshold) begin
                        cnt    <= '0;
                        idx    <= nxt[2:0];
                        dir    <= nxt[3];
                        step_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end

        // The white override is purely combinational, so it also applies
        // while the channel is held in reset.
        assign lights_out[RGB_W*c +: RGB_W] = lights_sel[c] ? colour_q : '1;
        assign colour_idx[3*c +: 3]         = idx;
        assign step[c]                      = step_q;
    end

endmodule

// File: tb/tb_rgb_seq_multi.sv
module tb_rgb_seq_multi;

    localparam int CH   = 2;
    localparam int SMIN = 1;
    localparam int SMAX = 6;
    localparam int NPOS = SMAX - SMIN + 1;

    logic          clk;
    logic          rst_n;
    logic [1:0]    button;
    logic [1:0]    lights_sel;
    logic [3:0]    mode;
    logic [5:0]    threshold;
    logic [47:0]   lights_out;
    logic [5:0]    colour_idx;
    logic [1:0]    step;

    int n_compared;
    int n_mismatched;

    // Reference model state, per channel
    int m_idx   [CH];
    int m_cnt   [CH];
    int m_dir   [CH];
    int m_shown [CH];
    int m_step  [CH];

    int        fwd_idx [6] = '{2, 3, 4, 5, 6, 1};
    logic [23:0] fwd_col [6] = '{24'h00FF00, 24'h00FFFF, 24'hFF0000,
                                 24'hFF00FF, 24'hFFFF00, 24'h0000FF};
    int        bnc_idx [11] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2};

    rgb_seq_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .lights_sel (lights_sel),
        .mode       (mode),
        .threshold  (threshold),
        .lights_out (lights_out),
        .colour_idx (colour_idx),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Colour for each palette index, as written in the colour table.
    function automatic logic [23:0] exp_colour(input int i);
        case (i)
            0:       return 24'h000000;
            1:       return 24'h0000FF;
            2:       return 24'h00FF00;
            3:       return 24'h00FFFF;
            4:       return 24'hFF0000;
            5:       return 24'hFF00FF;
            6:       return 24'hFFFF00;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Next position as {dir*16 + idx}. Forward/reverse are modular steps
    // around the ring of NPOS positions; bounce turns around at the ends.
    function automatic int model_next(input int idx, input int md, input int d);
        int ni;
        int nd;
        ni = idx;
        nd = d;
        if (md == 0) begin
            ni = SMIN + ((idx - SMIN + 1) % NPOS);
        end else if (md == 2) begin
            ni = SMIN + ((idx - SMIN + NPOS - 1) % NPOS);
        end else if (md == 1) begin
            if (idx == SMAX)      nd = 0;
            else if (idx == SMIN) nd = 1;
            ni = (nd == 1) ? idx + 1 : idx - 1;
        end
        return ni + 16 * nd;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_idx[c]   <= SMIN;
                m_cnt[c]   <= 0;
                m_dir[c]   <= 1;
                m_shown[c] <= SMIN;
                m_step[c]  <= 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                int md;
                int nx;
                md = int'(mode[2*c +: 2]);
                nx = model_next(m_idx[c], md, m_dir[c]);
                m_shown[c] <= m_idx[c];
                m_step[c]  <= 0;
                if (button[c] && md != 3) begin
                    if (m_cnt[c] >= int'(threshold)) begin
                        m_cnt[c]  <= 0;
                        m_idx[c]  <= nx % 16;
                        m_dir[c]  <= nx / 16;
                        m_step[c] <= 1;
                    end else begin
                        m_cnt[c] <= m_cnt[c] + 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [47:0] actual,
                               input logic [47:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("model_idx_ch%0d", c), 48'(colour_idx[3*c +: 3]), 48'(m_idx[c]));
            checkOutput($sformatf("model_step_ch%0d", c), 48'(step[c]), 48'(m_step[c]));
            checkOutput($sformatf("model_rgb_ch%0d", c), 48'(lights_out[24*c +: 24]),
                        48'(lights_sel[c] ? exp_colour(m_shown[c]) : 24'hFFFFFF));
        end
    end

    task automatic applyStimulus(input logic [1:0] btn, input logic [1:0] sel,
                                 input logic [3:0] md, input logic [5:0] thr);
        button     = btn;
        lights_sel = sel;
        mode       = md;
        threshold  = thr;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b1;
        applyStimulus(2'b00, 2'b11, 4'b0000, 6'd10);
        #1 rst_n = 1'b0;

        // Reset state and override during reset
        waitEdges(5);
        checkOutput("rst_rgb", lights_out, {2{24'h0000FF}});
        checkOutput("rst_idx", 48'(colour_idx), 48'(6'b001_001));
        checkOutput("rst_step", 48'(step), 48'd0);
        lights_sel = 2'b00;
        #1 checkOutput("rst_white", lights_out, {2{24'hFFFFFF}});
        lights_sel = 2'b11;
        #1 rst_n = 1'b1;

        // Forward on ch0, dwell of 11 clocks
        applyStimulus(2'b01, 2'b11, 4'b0000, 6'd10);
        for (int k = 0; k < 6; k++) begin
            waitEdges(k == 0 ? 11 : 10);
            checkOutput($sformatf("fwd_idx%0d", k), 48'(colour_idx[2:0]), 48'(fwd_idx[k]));
            checkOutput($sformatf("fwd_step%0d", k), 48'(step[0]), 48'd1);
            waitEdges(1);
            checkOutput($sformatf("fwd_rgb%0d", k), 48'(lights_out[23:0]), 48'(fwd_col[k]));
            checkOutput($sformatf("fwd_stepoff%0d", k), 48'(step[0]), 48'd0);
        end

        // Bounce on ch1 every clock, ch0 released
        applyStimulus(2'b10, 2'b11, 4'b0100, 6'd0);
        for (int k = 0; k < 11; k++) begin
            waitEdges(1);
            checkOutput($sformatf("bnc_idx%0d", k), 48'(colour_idx[5:3]), 48'(bnc_idx[k]));
            checkOutput($sformatf("bnc_ch0_hold%0d", k), 48'(colour_idx[2:0]), 48'd1);
        end

        // Reverse on ch0 from index 1
        applyStimulus(2'b01, 2'b11, 4'b0110, 6'd0);
        waitEdges(1);
        checkOutput("rev_6", 48'(colour_idx[2:0]), 48'd6);
        waitEdges(1);
        checkOutput("rev_5", 48'(colour_idx[2:0]), 48'd5);
        waitEdges(1);
        checkOutput("rev_4", 48'(colour_idx[2:0]), 48'd4);

        // Hold mid-dwell, with ch0 forced white meanwhile
        threshold = 6'd10;
        waitEdges(5);
        applyStimulus(2'b01, 2'b10, 4'b0111, 6'd10);
        #1 checkOutput("hold_white", 48'(lights_out[23:0]), 48'hFFFFFF);
        waitEdges(30);
        checkOutput("hold_idx", 48'(colour_idx[2:0]), 48'd4);
        applyStimulus(2'b01, 2'b11, 4'b0110, 6'd10);
        waitEdges(5);
        checkOutput("resume_wait", 48'(colour_idx[2:0]), 48'd4);
        waitEdges(1);
        checkOutput("resume_adv", 48'(colour_idx[2:0]), 48'd3);
        checkOutput("resume_step", 48'(step[0]), 48'd1);

        // Threshold lowered below the running count
        threshold = 6'd20;
        waitEdges(10);
        checkOutput("thr_before", 48'(colour_idx[2:0]), 48'd3);
        threshold = 6'd3;
        waitEdges(1);
        checkOutput("thr_now", 48'(colour_idx[2:0]), 48'd2);
        waitEdges(3);
        checkOutput("thr_dwell", 48'(colour_idx[2:0]), 48'd2);
        waitEdges(1);
        checkOutput("thr_next", 48'(colour_idx[2:0]), 48'd1);
        waitEdges(4);
        checkOutput("thr_wrap", 48'(colour_idx[2:0]), 48'd6);

        // Asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        checkOutput("arst_idx", 48'(colour_idx), 48'(6'b001_001));
        checkOutput("arst_rgb", lights_out, {2{24'h0000FF}});
        checkOutput("arst_step", 48'(step), 48'd0);
        waitEdges(2);
        rst_n = 1'b1;
        waitEdges(3);
        checkOutput("post_rst_wait", 48'(colour_idx[2:0]), 48'd1);
        waitEdges(1);
        checkOutput("post_rst_adv", 48'(colour_idx[2:0]), 48'd6);
        checkOutput("post_rst_step", 48'(step[0]), 48'd1);
        waitEdges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rgb_seq_multi.md
Name: rgb_seq_multi

Overview:
- Multi-channel successor to the single light sequencer: each channel steps an RGB colour through a fixed palette sequence at a programmable dwell rate while its enable (button) is held.
- Adds per-channel sequencing modes (forward, reverse, bounce, hold), per-channel white override, parametrised colour depth and channel count, and a per-channel step strobe.
- Sits between the user-input/debounce logic and the LED driver in the top-level lighting path.

Parameters:
- CHANNELS, 2, number of independent light channels
- COLOR_W, 8, bits per colour component; each RGB word is 3*COLOR_W wide
- CNT_W, 6, width of the shared dwell threshold and of each channel's dwell counter
- SEQ_MIN, 1, first palette index in the sequence (1..6)
- SEQ_MAX, 6, last palette index in the sequence (SEQ_MIN < SEQ_MAX <= 6)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- button  input  CHANNELS  per-channel sequence enable
- lights_sel  input  CHANNELS  1 = sequencer colour, 0 = white override
- mode  input  2*CHANNELS  per-channel mode, channel c at [2c+1:2c]
- threshold  input  CNT_W  shared dwell threshold (unsigned)
- lights_out  output  CHANNELS*3*COLOR_W  per-channel RGB, channel c at [3*COLOR_W*(c+1)-1 : 3*COLOR_W*c], order {R,G,B}
- colour_idx  output  3*CHANNELS  per-channel current palette index
- step  output  CHANNELS  one-cycle pulse on each index advance

Behaviour:
- Palette: 3-bit index i; R = {COLOR_W{i[2]}}, G = {COLOR_W{i[1]}}, B = {COLOR_W{i[0]}}. Index 1 = 0000FF, 2 = 00FF00, 3 = 00FFFF, 4 = FF0000, 5 = FF00FF, 6 = FFFF00, 7 = white (shown for COLOR_W=8).
- Per-channel state: idx (3b), cnt (CNT_W), dir (1b, 1 = up), colour_q (3*COLOR_W), step_q.
- Reset (async, rst_n=0): idx=SEQ_MIN, cnt=0, dir=1, colour_q=palette(SEQ_MIN), step=0. Held in reset for the whole low period.
- Dwell: each rising edge with button[c]=1 and mode!=11: if cnt >= threshold then cnt<=0 and idx advances, else cnt<=cnt+1. Comparison is unsigned. threshold=0 advances every cycle.
- button[c]=0 or mode=11 (hold): cnt, idx, dir frozen (cnt is not cleared).
- Advance rules: mode 00 forward, SEQ_MAX wraps to SEQ_MIN. Mode 10 reverse, SEQ_MIN wraps to SEQ_MAX. Mode 01 bounce: move in direction dir; at SEQ_MAX flip dir to 0 and step down; at SEQ_MIN flip dir to 1 and step up. No repeat at the ends: 1,2,...,6,5,...,1,2.
- dir is used only in bounce mode and retains its value across mode changes. A mode change takes effect at the next advance edge.
- step[c] is registered and asserted for exactly the cycle after the edge on which idx changed.
- colour_q <= palette(idx) every edge, giving 1-cycle latency from idx to colour. colour_idx = idx.
- First advance after button rises: threshold+1 enabled edges, plus 1 edge for the colour to appear.
- Threshold lowered below the current cnt mid-dwell: advance on the next enabled edge.
- lights_out (combinational) = lights_sel[c] ? colour_q : all-ones. The override takes priority over reset state, so sel=0 gives white even while rst_n=0.
- Channels are fully independent apart from the shared threshold.

Test Plan:
- Reset: rst_n=0 for 5 cycles, lights_sel=2'b11 -> every channel lights_out=0000FF, colour_idx=1, step=0. Set lights_sel=0 during reset -> FFFFFF.
- Forward, threshold=10, ch0 button=1, mode=00: colour changes every 11 cycles through 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, 0000FF (wrap). step pulses once per change.
- Bounce on ch1 (mode=01), threshold=0: colour_idx sequence 2,3,4,5,6,5,4,3,2,1,2 on consecutive edges. ch0 with button=0 holds its value throughout.
- Reverse (mode=10) from idx 1 -> 6,5,4. Switch to hold (11) mid-dwell -> idx and cnt frozen for 30 cycles. Switch back -> advance after the remaining dwell only.
- Threshold 20 -> 3 while cnt=10 -> advance on the next enabled edge, then every 4 cycles.
- Async reset mid-run: drop rst_n between clock edges -> immediately idx=1, colour 0000FF. Release -> with button held, first advance after threshold+1 edges.
